// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch front-end that prefetches instructions from a variable-latency memory into a small FIFO for decode.
// Ports:
//   clk, reset                   clock; asynchronous active-high reset
//   imem_req, imem_addr          fetch request to instruction memory (accepted in the same cycle)
//   imem_rvalid, imem_rdata      memory response for the single outstanding request
//   redirect_valid, redirect_pc  flush everything and restart fetching at redirect_pc
//   if_valid, if_instr, if_pc    FIFO head presented to decode
//   id_ready                     decode consumes the head this cycle
module instr_fetch_unit #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic               outstanding_q, outstanding_d, discard_q, discard_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_d [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic               resp, push, pop;
    logic [CW:0]        credit;

    // An outstanding request reserves a FIFO slot, so a response can always be pushed.
    assign credit    = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
    assign imem_req  = !reset && !redirect_valid && (!outstanding_q || imem_rvalid)
                       && (credit < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign resp      = imem_rvalid && outstanding_q;
    assign push      = resp && !discard_q && !redirect_valid;
    assign if_valid  = count_q != '0;
    assign pop       = if_valid && id_ready;
    assign if_instr  = instr_mem_q[rd_ptr_q];
    assign if_pc     = pc_mem_q[rd_ptr_q];

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]    = resp_pc_q;
            instr_mem_d[wr_ptr_q] = imem_rdata;
        end
        fetch_pc_d    = redirect_valid ? redirect_pc : imem_req ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
        resp_pc_d     = imem_req ? fetch_pc_q : resp_pc_q;
        // A request still in flight at redirect stays outstanding but its data is marked for discard.
        outstanding_d = imem_req || (outstanding_q && !imem_rvalid);
        discard_d     = redirect_valid ? (outstanding_q && !imem_rvalid) : (discard_q && !resp);
        count_d       = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = redirect_valid ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d      = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            resp_pc_q     <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pc_mem_q      <= pc_mem_d;
            instr_mem_q   <= instr_mem_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks of instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [3:0]  redirect_pc = '0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [3:0]  if_pc;
    logic        id_ready = 1'b0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] pc; logic [15:0] instr; } ent_t;
    typedef struct { int rc; logic [3:0] a; } pend_t;
    localparam logic [15:0] LIT [4] = '{16'h1234, 16'h0290, 16'h2E04, 16'hFFFF};

    logic [15:0] memimg [16];
    pend_t       pq [$];
    ent_t        m_q [$];
    logic [3:0]  m_fetch = '0, m_resp_pc = '0, exp_next = '0;
    bit          m_out = 0, m_disc = 0;
    int          cyc = 0, lat_min = 1, lat_max = 1;
    bit          spur_en = 0;
    bit          st_reset = 1, st_redir = 0, st_ready = 0;
    logic [3:0]  st_rpc = '0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        bit exp_req, pop, resp;
        @(negedge clk);
        reset = st_reset;
        redirect_valid = st_redir;
        redirect_pc = st_rpc;
        id_ready = st_ready;
        if (pq.size() != 0 && pq[0].rc == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = memimg[pq[0].a];
            void'(pq.pop_front());
        end else begin
            imem_rvalid = spur_en && pq.size() == 0 && $urandom_range(7) == 0;
            imem_rdata = 16'($urandom);
        end
        if (st_reset) begin
            m_q.delete();
            m_fetch = '0; m_resp_pc = '0; m_out = 0; m_disc = 0; exp_next = '0;
        end
        #1;
        exp_req = !st_reset && !st_redir && (!m_out || imem_rvalid) && (m_q.size() + int'(m_out) < 4);
        chk("imem_req", imem_req, exp_req);
        chk("imem_addr", imem_addr, m_fetch);
        chk("if_valid", if_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("if_pc", if_pc, m_q[0].pc);
            chk("if_instr", if_instr, m_q[0].instr);
        end
        if (st_reset) begin
            chk("reset_instr", if_instr, 0);
            chk("reset_pc", if_pc, 0);
        end
        pop = !st_reset && st_ready && m_q.size() != 0;
        if (pop) begin
            chk("deliver_pc", if_pc, exp_next);
            chk("deliver_instr", if_instr, memimg[if_pc]);
            exp_next = exp_next + 4'd1;
        end
        if (!st_reset) begin
            if (st_redir) begin
                m_q.delete();
                m_fetch = st_rpc;
                exp_next = st_rpc;
                if (m_out && !imem_rvalid) m_disc = 1;
                else begin m_out = 0; m_disc = 0; end
            end else begin
                resp = imem_rvalid && m_out;
                if (pop) void'(m_q.pop_front());
                if (resp && !m_disc) m_q.push_back('{pc: m_resp_pc, instr: imem_rdata});
                if (resp) begin m_out = 0; m_disc = 0; end
                if (exp_req) begin m_out = 1; m_resp_pc = m_fetch; m_fetch = m_fetch + 4'd1; end
            end
        end
        if (imem_req) pq.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), imem_addr});
        cyc++;
    endtask

    task automatic do_reset(input int n);
        st_reset = 1;
        repeat (n) tick();
        st_reset = 0;
    endtask

    initial begin
        int nreq, nval;
        bit found;
        for (int i = 0; i < 16; i++) memimg[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) memimg[i] = LIT[i];

        // reset release, L=1, streaming
        st_ready = 1;
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) begin
                chk("t1_req", imem_req, 1);
                chk("t1_addr", imem_addr, i);
            end
            if (i >= 2) begin
                chk("t1_valid", if_valid, 1);
                chk("t1_pc", if_pc, i - 2);
                chk("t1_instr", if_instr, LIT[i-2]);
            end
        end

        // L=3: one request and one valid pulse every 3 cycles
        lat_min = 3; lat_max = 3;
        repeat (6) tick();
        nreq = 0; nval = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            nreq += int'(imem_req);
            nval += int'(if_valid);
        end
        chk("t2_req_count", nreq, 8);
        chk("t2_valid_count", nval, 8);

        // backpressure, L=1
        lat_min = 1; lat_max = 1; st_ready = 0;
        do_reset(5);
        repeat (10) tick();
        chk("t3_req_stalled", imem_req, 0);
        chk("t3_full_valid", if_valid, 1);
        chk("t3_head_pc", if_pc, 0);
        st_ready = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_drain_valid", if_valid, 1);
            chk("t3_drain_pc", if_pc, i);
        end

        // redirect to 0xA while addr 5 is outstanding with {3,4} buffered
        lat_min = 3; lat_max = 3; st_ready = 0;
        st_redir = 1; st_rpc = 4'h3;
        tick();
        st_redir = 0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = m_out && m_resp_pc == 4'h5 && m_q.size() == 2;
        end
        chk("t4_setup", found, 1);
        chk("t4_head_before", if_pc, 3);
        st_redir = 1; st_rpc = 4'hA;
        tick();
        st_redir = 0;
        st_ready = 1;
        tick();
        chk("t4_flushed", if_valid, 0);
        found = imem_req;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = imem_req;
        end
        chk("t4_req_seen", found, 1);
        chk("t4_req_addr", imem_addr, 4'hA);
        found = if_valid;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = if_valid;
        end
        chk("t4_valid_seen", found, 1);
        chk("t4_first_pc", if_pc, 4'hA);

        // wrap-around after redirect to 0xE, L=1
        lat_min = 1; lat_max = 1;
        repeat (4) tick();
        st_redir = 1; st_rpc = 4'hE;
        tick();
        st_redir = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = if_valid;
        end
        chk("t5_valid_seen", found, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_valid", if_valid, 1);
            chk("t5_pc", if_pc, (14 + i) % 16);
            tick();
        end

        // one-cycle reset with a request in flight; its late response must be ignored
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            found = pq.size() != 0 && pq[0].rc == cyc + 2;
        end
        chk("t6_setup", found, 1);
        tick();
        st_reset = 1;
        tick();
        st_reset = 0;
        tick();
        chk("t6_stale_rvalid", imem_rvalid, 1);
        chk("t6_restart_req", imem_req, 1);
        chk("t6_restart_addr", imem_addr, 0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = if_valid;
        end
        chk("t6_valid_seen", found, 1);
        chk("t6_first_pc", if_pc, 0);
        chk("t6_first_instr", if_instr, LIT[0]);

        // randomized traffic
        lat_min = 1; lat_max = 4; spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            st_ready = $urandom_range(3) != 0;
            st_redir = $urandom_range(31) == 0;
            st_rpc = 4'($urandom);
            tick();
        end
        st_redir = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
